// File: rtl/serpent_round_sequencer.sv
// ---------------------------------------------------------------------------
// serpent_round_sequencer
//
// Iterative controller that walks one 128-bit Serpent block through ROUNDS
// iterations of a single shared, purely combinational external round unit.
// An accepted block is passed through the initial permutation (IP) into the
// state register. The state, round index and direction are then presented to
// the round unit for ROUNDS cycles. The final-permuted (FP) result is then
// held on a valid/ready output.
//
// Ports:
//   i_clk, i_rst        clock (rising edge), asynchronous active-high reset
//   i_valid/o_ready     input handshake; i_data and i_decrypt sampled on accept
//   o_rnd_state         state register, fed to the round unit
//   o_rnd_idx           current round number
//   o_rnd_dec           latched direction (1 = decrypt)
//   o_rnd_last          current round is the final iteration
//   i_rnd_result        round unit output for the presented state/idx/dir
//   o_valid/i_ready     output handshake; o_data is stable while o_valid
//   o_busy              block in flight (RUN or DONE)
// ---------------------------------------------------------------------------
module serpent_round_sequencer #(
    parameter int ROUNDS = 32,
    parameter int IDX_W  = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [127:0]     i_data,
    input  logic             i_decrypt,
    output logic [127:0]     o_rnd_state,
    output logic [IDX_W-1:0] o_rnd_idx,
    output logic             o_rnd_dec,
    output logic             o_rnd_last,
    input  logic [127:0]     i_rnd_result,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [127:0]     o_data,
    output logic             o_busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

    // Bit ordering: the permuted word read MSB-first is
    // d[0], d[32], d[64], d[96], d[1], d[33], ... so source bit 32j+k
    // lands at position 127-(4k+j).
    function automatic logic [127:0] f_ip(input logic [127:0] d);
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 32; k++) begin
            for (int j = 0; j < 4; j++) begin
                o[127 - (4*k + j)] = d[32*j + k];
            end
        end
        return o;
    endfunction

    // Exact inverse of f_ip.
    function automatic logic [127:0] f_fp(input logic [127:0] d);
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 32; k++) begin
            for (int j = 0; j < 4; j++) begin
                o[32*j + k] = d[127 - (4*k + j)];
            end
        end
        return o;
    endfunction

    logic [1:0]       r_fsm;
    logic [127:0]     r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_dec;
    logic [127:0]     r_data;
    logic             w_last;

    // The final round is reached at the far end of the index range for the
    // latched direction; qualified by RUN so it reads 0 in IDLE and DONE.
    assign w_last = (r_fsm == S_RUN) &&
                    (r_dec ? (r_idx == '0) : (r_idx == LAST_IDX));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fsm   <= S_IDLE;
            r_state <= '0;
            r_idx   <= '0;
            r_dec   <= 1'b0;
            r_data  <= '0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (i_valid) begin
                        r_state <= f_ip(i_data);
                        r_dec   <= i_decrypt;
                        r_idx   <= i_decrypt ? LAST_IDX : '0;
                        r_fsm   <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_state <= i_rnd_result;
                    if (w_last) begin
                        // Index holds its final value, so it never leaves
                        // the 0..ROUNDS-1 range outside RUN.
                        r_data <= f_fp(i_rnd_result);
                        r_fsm  <= S_DONE;
                    end else if (r_dec) begin
                        r_idx <= r_idx - 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (i_ready) begin
                        r_fsm <= S_IDLE;
                    end
                end
                default: begin
                    r_fsm <= S_IDLE;
                end
            endcase
        end
    end

    // All outputs decode registers only; nothing passes combinationally
    // from i_ready or i_valid.
    assign o_ready     = (r_fsm == S_IDLE);
    assign o_valid     = (r_fsm == S_DONE);
    assign o_busy      = (r_fsm == S_RUN) || (r_fsm == S_DONE);
    assign o_rnd_state = r_state;
    assign o_rnd_idx   = r_idx;
    assign o_rnd_dec   = r_dec;
    assign o_rnd_last  = w_last;
    assign o_data      = r_data;

endmodule
